// File: rtl/johnson_phase_decoder.sv
// Decodes a 4-bit Johnson ring counter into a phase index/strobe, tracks lock and rotations.
// Optional err_count output is enabled by defining JOHNSON_DEC_ERRCNT_EN.
module johnson_phase_decoder #(
  parameter int unsigned LOCK_COUNT = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [3:0]       i_q_in,
  input  logic             i_clr_err,
  output logic [2:0]       o_phase,
  output logic [7:0]       o_phase_onehot,
  output logic             o_valid,
  output logic             o_locked,
  output logic             o_err_illegal,
  output logic             o_err_skip,
  output logic             o_err_sticky,
  output logic [CNT_W-1:0] o_rotation_cnt,
  output logic             o_rot_pulse
`ifdef JOHNSON_DEC_ERRCNT_EN
  ,
  output logic [7:0]       o_err_count
`endif
);

  localparam logic [1:0] StHunt   = 2'd0;
  localparam logic [1:0] StTrack  = 2'd1;
  localparam logic [1:0] StLocked = 2'd2;

  localparam logic [2:0] LockCnt = 3'(LOCK_COUNT);

  logic [3:0]       r_s1_q;
  logic             r_s1_v;
  logic [1:0]       r_state;
  logic [2:0]       r_run;
  logic [2:0]       r_phase;
  logic [7:0]       r_onehot;
  logic             r_valid;
  logic             r_err_illegal;
  logic             r_err_skip;
  logic             r_err_sticky;
  logic [CNT_W-1:0] r_rot_cnt;
  logic             r_rot_pulse;

  logic             w_legal;
  logic [2:0]       w_dec_phase;
  logic [2:0]       w_next_phase;
  logic [2:0]       w_run_inc;
  logic             w_succ;
  logic             w_same;
  logic [1:0]       w_state_d;
  logic [2:0]       w_run_d;
  logic [2:0]       w_phase_d;
  logic [7:0]       w_onehot_d;
  logic             w_valid_d;
  logic             w_ill_d;
  logic             w_skip_d;
  logic             w_err_d;
  logic             w_sticky_d;
  logic [CNT_W-1:0] w_rot_d;
  logic             w_rotp_d;

  always_comb begin
    w_legal     = 1'b1;
    w_dec_phase = 3'd0;
    case (r_s1_q)
      4'b0000: w_dec_phase = 3'd0;
      4'b0001: w_dec_phase = 3'd1;
      4'b0011: w_dec_phase = 3'd2;
      4'b0111: w_dec_phase = 3'd3;
      4'b1111: w_dec_phase = 3'd4;
      4'b1110: w_dec_phase = 3'd5;
      4'b1100: w_dec_phase = 3'd6;
      4'b1000: w_dec_phase = 3'd7;
      default: w_legal     = 1'b0;
    endcase
  end

  assign w_next_phase = r_phase + 3'd1;
  assign w_run_inc    = r_run + 3'd1;
  assign w_succ       = (w_dec_phase == w_next_phase);
  assign w_same       = (w_dec_phase == r_phase);

  always_comb begin
    w_state_d = r_state;
    w_run_d   = r_run;
    w_phase_d = r_phase;
    w_valid_d = r_valid;
    w_ill_d   = 1'b0;
    w_skip_d  = 1'b0;
    w_rot_d   = r_rot_cnt;
    w_rotp_d  = 1'b0;
    if (r_s1_v) begin
      if (!w_legal) begin
        w_ill_d   = 1'b1;
        w_valid_d = 1'b0;
        w_state_d = StHunt;
      end else begin
        w_valid_d = 1'b1;
        w_phase_d = w_dec_phase;
        case (r_state)
          StHunt: begin
            w_state_d = StTrack;
            w_run_d   = 3'd0;
          end
          StTrack: begin
            if (w_succ) begin
              w_run_d = w_run_inc;
              if (w_run_inc == LockCnt) w_state_d = StLocked;
            end else if (!w_same) begin
              w_run_d = 3'd0;
            end
          end
          StLocked: begin
            if (w_succ) begin
              // 7 -> 0 closes a full rotation
              if (r_phase == 3'd7) begin
                w_rot_d  = r_rot_cnt + CNT_W'(1);
                w_rotp_d = 1'b1;
              end
            end else if (!w_same) begin
              w_skip_d  = 1'b1;
              w_state_d = StTrack;
              w_run_d   = 3'd0;
            end
          end
          default: begin
            w_state_d = StHunt;
            w_run_d   = 3'd0;
          end
        endcase
      end
    end
  end

  assign w_onehot_d = w_valid_d ? (8'd1 << w_phase_d) : 8'd0;
  assign w_err_d    = w_ill_d | w_skip_d;
  // A new error outranks a simultaneous clear
  assign w_sticky_d = w_err_d ? 1'b1 : (i_clr_err ? 1'b0 : r_err_sticky);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_s1_q        <= 4'd0;
      r_s1_v        <= 1'b0;
      r_state       <= StHunt;
      r_run         <= 3'd0;
      r_phase       <= 3'd0;
      r_onehot      <= 8'd0;
      r_valid       <= 1'b0;
      r_err_illegal <= 1'b0;
      r_err_skip    <= 1'b0;
      r_err_sticky  <= 1'b0;
      r_rot_cnt     <= '0;
      r_rot_pulse   <= 1'b0;
    end else begin
      r_s1_v <= i_en;
      if (i_en) r_s1_q <= i_q_in;
      r_state       <= w_state_d;
      r_run         <= w_run_d;
      r_phase       <= w_phase_d;
      r_onehot      <= w_onehot_d;
      r_valid       <= w_valid_d;
      r_err_illegal <= w_ill_d;
      r_err_skip    <= w_skip_d;
      r_err_sticky  <= w_sticky_d;
      r_rot_cnt     <= w_rot_d;
      r_rot_pulse   <= w_rotp_d;
    end
  end

`ifdef JOHNSON_DEC_ERRCNT_EN
  logic [7:0] r_err_count;
  logic [7:0] w_err_count_d;

  always_comb begin
    w_err_count_d = r_err_count;
    if (w_err_d) begin
      if (i_clr_err)                 w_err_count_d = 8'd1;
      else if (r_err_count != 8'hFF) w_err_count_d = r_err_count + 8'd1;
    end else if (i_clr_err) begin
      w_err_count_d = 8'd0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) r_err_count <= 8'd0;
    else         r_err_count <= w_err_count_d;
  end

  assign o_err_count = r_err_count;
`endif

  assign o_phase        = r_phase;
  assign o_phase_onehot = r_onehot;
  assign o_valid        = r_valid;
  assign o_locked       = (r_state == StLocked);
  assign o_err_illegal  = r_err_illegal;
  assign o_err_skip     = r_err_skip;
  assign o_err_sticky   = r_err_sticky;
  assign o_rotation_cnt = r_rot_cnt;
  assign o_rot_pulse    = r_rot_pulse;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Scoreboard bench for johnson_phase_decoder: stimulus pushes expected outputs, monitor compares.
// Define JOHNSON_DEC_ERRCNT_EN to also exercise err_count.
module tb_johnson_phase_decoder;
  localparam int unsigned LOCK_COUNT = 2;
  localparam int unsigned CNT_W      = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en  = 1'b0;
  logic             clr = 1'b0;
  logic [3:0]       q   = 4'd0;
  logic [2:0]       phase;
  logic [7:0]       onehot;
  logic             valid, locked, ill, skip, sticky, rotp;
  logic [CNT_W-1:0] rot;
`ifdef JOHNSON_DEC_ERRCNT_EN
  logic [7:0]       errcnt;
`endif

  always #5 clk = ~clk;

  johnson_phase_decoder #(.LOCK_COUNT(LOCK_COUNT), .CNT_W(CNT_W)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_en          (en),
    .i_q_in        (q),
    .i_clr_err     (clr),
    .o_phase       (phase),
    .o_phase_onehot(onehot),
    .o_valid       (valid),
    .o_locked      (locked),
    .o_err_illegal (ill),
    .o_err_skip    (skip),
    .o_err_sticky  (sticky),
    .o_rotation_cnt(rot),
    .o_rot_pulse   (rotp)
`ifdef JOHNSON_DEC_ERRCNT_EN
    ,
    .o_err_count   (errcnt)
`endif
  );

  typedef struct {
    int phase, onehot, valid, locked, ill, skip, sticky, rotp, rot, errcnt;
    bit h_en;
    int h_phase, h_valid, h_locked, h_rot, h_sticky, h_ill, h_skip;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  logic [3:0] codes [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  // reference model state
  logic [3:0] m_s1q = 4'd0;
  bit  m_s1v = 0;
  int  m_state = 0, m_run = 0, m_phase = 0, m_valid = 0, m_rot = 0, m_sticky = 0;
  int  m_ill = 0, m_skip = 0, m_rotp = 0, m_errcnt = 0;

  // pending hand-computed expectation for the next step
  bit hp_en = 0;
  int hp_phase, hp_valid, hp_locked, hp_rot, hp_sticky, hp_ill, hp_skip;

  function automatic int dec(logic [3:0] c);
    for (int i = 0; i < 8; i++) if (codes[i] == c) return i;
    return -1;
  endfunction

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
    end
  endfunction

  task automatic hand(input int ph, vl, lk, rc, st, il, sk);
    hp_en = 1; hp_phase = ph; hp_valid = vl; hp_locked = lk; hp_rot = rc;
    hp_sticky = st; hp_ill = il; hp_skip = sk;
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] c, input logic cl);
    exp_t x;
    int   p;
    @(negedge clk);
    rst = r; en = e; q = c; clr = cl;
    if (r) begin
      m_s1q = 4'd0; m_s1v = 0; m_state = 0; m_run = 0; m_phase = 0; m_valid = 0;
      m_rot = 0; m_sticky = 0; m_ill = 0; m_skip = 0; m_rotp = 0; m_errcnt = 0;
    end else begin
      m_ill = 0; m_skip = 0; m_rotp = 0;
      if (m_s1v) begin
        p = dec(m_s1q);
        if (p < 0) begin
          m_ill = 1; m_valid = 0; m_state = 0;
        end else begin
          m_valid = 1;
          if (m_state == 0) begin
            m_state = 1; m_run = 0;
          end else if (p == (m_phase + 1) % 8) begin
            if (m_state == 1) begin
              m_run++;
              if (m_run == LOCK_COUNT) m_state = 2;
            end else if (m_phase == 7) begin
              m_rot = (m_rot + 1) % (1 << CNT_W); m_rotp = 1;
            end
          end else if (p != m_phase) begin
            if (m_state == 2) m_skip = 1;
            m_state = 1; m_run = 0;
          end
          m_phase = p;
        end
      end
      if (m_ill || m_skip) begin
        m_sticky = 1;
        m_errcnt = cl ? 1 : (m_errcnt < 255 ? m_errcnt + 1 : 255);
      end else if (cl) begin
        m_sticky = 0; m_errcnt = 0;
      end
      m_s1v = e;
      if (e) m_s1q = c;
    end
    x.phase = m_phase; x.valid = m_valid; x.onehot = m_valid ? (1 << m_phase) : 0;
    x.locked = (m_state == 2) ? 1 : 0; x.ill = m_ill; x.skip = m_skip; x.sticky = m_sticky;
    x.rotp = m_rotp; x.rot = m_rot; x.errcnt = m_errcnt;
    x.h_en = hp_en; x.h_phase = hp_phase; x.h_valid = hp_valid; x.h_locked = hp_locked;
    x.h_rot = hp_rot; x.h_sticky = hp_sticky; x.h_ill = hp_ill; x.h_skip = hp_skip;
    hp_en = 0;
    sbq.push_back(x);
  endtask

  // monitor: one expected entry per clock edge after it was issued
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      chk("phase", int'(phase), x.phase);
      chk("phase_onehot", int'(onehot), x.onehot);
      chk("valid", int'(valid), x.valid);
      chk("locked", int'(locked), x.locked);
      chk("err_illegal", int'(ill), x.ill);
      chk("err_skip", int'(skip), x.skip);
      chk("err_sticky", int'(sticky), x.sticky);
      chk("rot_pulse", int'(rotp), x.rotp);
      chk("rotation_cnt", int'(rot), x.rot);
`ifdef JOHNSON_DEC_ERRCNT_EN
      chk("err_count", int'(errcnt), x.errcnt);
`endif
      if (x.h_en) begin
        chk("hand_phase", int'(phase), x.h_phase);
        chk("hand_valid", int'(valid), x.h_valid);
        chk("hand_locked", int'(locked), x.h_locked);
        chk("hand_rotation_cnt", int'(rot), x.h_rot);
        chk("hand_err_sticky", int'(sticky), x.h_sticky);
        chk("hand_err_illegal", int'(ill), x.h_ill);
        chk("hand_err_skip", int'(skip), x.h_skip);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    hand(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 4'h0, 0);
    // lock, then three full rotations ending with phase 2 sampled
    for (int i = 0; i < 27; i++) begin
      if (i == 3)  hand(2, 1, 1, 0, 0, 0, 0);
      if (i == 4)  hand(3, 1, 1, 0, 0, 0, 0);
      if (i == 25) hand(0, 1, 1, 3, 0, 0, 0);
      step(0, 1, codes[i % 8], 0);
    end
    hand(2, 1, 1, 3, 0, 0, 0);
    step(0, 1, 4'hF, 0);
    hand(4, 1, 0, 3, 1, 0, 1);
    step(0, 1, 4'hE, 0);
    step(0, 1, 4'hC, 0);
    hand(6, 1, 1, 3, 1, 0, 0);
    step(0, 1, 4'h8, 0);
    hand(7, 1, 1, 3, 1, 0, 0);
    step(0, 1, 4'h5, 0);
    hand(7, 0, 0, 3, 1, 1, 0);
    step(0, 0, 4'h5, 0);
    hand(7, 0, 0, 3, 0, 0, 0);
    step(0, 0, 4'h5, 1);
    step(0, 0, 4'h0, 0);
    // sparse enable, each code sampled twice, reset mid-sequence
    for (int i = 0; i < 36; i++) begin
      if (i == 14) hand(2, 1, 1, 3, 0, 0, 0);
      if (i == 20) hand(3, 1, 1, 3, 0, 0, 0);
      if (i == 30) hand(0, 0, 0, 0, 0, 0, 0);
      step(logic'(i == 30), logic'(i % 3 == 0), codes[(i / 6) % 8], 0);
    end
    for (int i = 0; i < 300; i++) step(0, 1, 4'h5, 0);
    hand(5, 0, 0, 0, 1, 1, 0);
    step(0, 1, 4'h5, 1);
    step(0, 0, 4'h0, 0);
    hand(5, 0, 0, 0, 0, 0, 0);
    step(0, 0, 4'h0, 1);
    step(0, 0, 4'h0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
